rfid_read_ctrl: RTL and testbench

- Read sequencer between the Manchester frame decoder and the ID/display path.
- Restarts the decoder, waits for decoded 45-bit frames and screens them by header.
- Commits an ID only after MATCH_COUNT consecutive identical good frames.
- Holds the committed ID while the tag stays present, and drops it after a no-tag hold timeout.

---
 rtl/rfid_read_ctrl.sv | 179 +++++++++++++++++
 tb/tb_rfid_read_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rfid_read_ctrl.sv
// Read sequencer: restarts the Manchester decoder, screens decoded frames by
// header and commits an ID after a run of identical good frames.
module rfid_read_ctrl #(
    parameter int               MATCH_COUNT    = 3,
    parameter logic [7:0]       HEADER         = 8'h1D,
    parameter int               RESTART_CYCLES = 64,
    parameter int               TIMEOUT_CYCLES = 1600000,
    parameter int               HOLD_CYCLES    = 32000000,
    parameter int               CNT_W          = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_valid,
    input  logic [44:0] frame_data,
    output logic        dec_restart,
    output logic [44:0] id_out,
    output logic        id_valid,
    output logic        id_new,
    output logic        timeout,
    output logic [7:0]  err_cnt,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CONFIRM = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    localparam logic [3:0]       MC       = 4'(MATCH_COUNT);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESTART_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [44:0]        cand_q, cand_d;
    logic [3:0]         match_q, match_d;
    logic [44:0]        id_q, id_d;
    logic               idv_q, idv_d;
    logic               new_q, new_d;
    logic               tmo_q, tmo_d;
    logic               rst_q, rst_d;
    logic [7:0]         err_q, err_d;
    logic               hdr_ok, good, bad;
    logic [3:0]         match_inc;

    assign hdr_ok    = frame_data[44:37] == HEADER;
    assign good      = frame_valid && hdr_ok;
    assign bad       = frame_valid && !hdr_ok;
    assign match_inc = match_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        cand_d  = cand_q;
        match_d = match_q;
        id_d    = id_q;
        idv_d   = idv_q;
        new_d   = 1'b0;
        tmo_d   = 1'b0;
        err_d   = err_q;

        if (bad && state_q != IDLE && err_q != 8'hFF)
            err_d = err_q + 8'd1;

        unique case (state_q)
            IDLE: begin
                // cnt only runs while the restart pulse is actually out
                cnt_d = rst_q ? cnt_q + 1'b1 : cnt_q;
                if (rst_q && cnt_q == RST_LAST)
                    state_d = ARM;
            end
            ARM: begin
                if (good) begin
                    cand_d  = frame_data;
                    match_d = 4'd1;
                    if (MC == 4'd1) begin
                        id_d    = frame_data;
                        idv_d   = 1'b1;
                        new_d   = 1'b1;
                        state_d = LOCKED;
                    end else begin
                        state_d = CONFIRM;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            CONFIRM: begin
                if (good) begin
                    cnt_d = '0;
                    if (frame_data == cand_q) begin
                        match_d = match_inc;
                        if (match_inc == MC) begin
                            id_d    = cand_q;
                            idv_d   = 1'b1;
                            new_d   = 1'b1;
                            state_d = LOCKED;
                        end
                    end else begin
                        cand_d  = frame_data;
                        match_d = 4'd1;
                    end
                end else if (bad) begin
                    cand_d  = '0;
                    match_d = 4'd0;
                    state_d = ARM;
                end else if (cnt_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                if (good) begin
                    if (frame_data == id_q) begin
                        cnt_d = '0;
                    end else begin
                        cand_d  = frame_data;
                        match_d = 4'd1;
                        if (MC == 4'd1) begin
                            id_d  = frame_data;
                            new_d = 1'b1;
                            cnt_d = '0;
                        end else begin
                            state_d = CONFIRM;
                        end
                    end
                end else if (cnt_q == HLD_LAST) begin
                    idv_d   = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase

        if (state_d != state_q)
            cnt_d = '0;
        if (state_d == IDLE)
            idv_d = 1'b0;
        rst_d = state_d == IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            match_q <= '0;
            id_q    <= '0;
            idv_q   <= 1'b0;
            new_q   <= 1'b0;
            tmo_q   <= 1'b0;
            rst_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            match_q <= match_d;
            id_q    <= id_d;
            idv_q   <= idv_d;
            new_q   <= new_d;
            tmo_q   <= tmo_d;
            rst_q   <= rst_d;
            err_q   <= err_d;
        end
    end

    assign dec_restart = rst_q;
    assign id_out      = id_q;
    assign id_valid    = idv_q;
    assign id_new      = new_q;
    assign timeout     = tmo_q;
    assign err_cnt     = err_q;
    assign state       = state_q;

endmodule

// File: tb/tb_rfid_read_ctrl.sv
// Directed bench for rfid_read_ctrl with short restart/timeout/hold counts.
module tb_rfid_read_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_valid;
    logic [44:0] frame_data;
    logic        dec_restart;
    logic [44:0] id_out;
    logic        id_valid;
    logic        id_new;
    logic        timeout;
    logic [7:0]  err_cnt;
    logic [1:0]  state;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [44:0] A   = {8'h1D, 37'h0_1234_5678};
    localparam logic [44:0] B   = {8'h1D, 37'h0_0ABC_DEF0};
    localparam logic [44:0] BAD = {8'h00, 37'h0_1234_5678};

    rfid_read_ctrl #(
        .MATCH_COUNT   (3),
        .HEADER        (8'h1D),
        .RESTART_CYCLES(4),
        .TIMEOUT_CYCLES(100),
        .HOLD_CYCLES   (200),
        .CNT_W         (25)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_valid(frame_valid),
        .frame_data (frame_data),
        .dec_restart(dec_restart),
        .id_out     (id_out),
        .id_valid   (id_valid),
        .id_new     (id_new),
        .timeout    (timeout),
        .err_cnt    (err_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [44:0] got,
                         input logic [44:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [44:0] d);
        frame_valid = 1'b1;
        frame_data  = d;
        step();
        frame_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_state(input string tag, input logic [1:0] s);
        int k = 0;
        while (state != s && k < 50) begin
            step();
            k++;
        end
        check(tag, 45'(state), 45'(s));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int k;
        int rcnt;
        logic seen;
        reset       = 1'b1;
        frame_valid = 1'b0;
        frame_data  = '0;
        idle(2);
        check("rst_state", 45'(state), 45'd0);
        check("rst_restart", 45'(dec_restart), 45'd0);
        check("rst_idv", 45'(id_valid), 45'd0);
        check("rst_err", 45'(err_cnt), 45'd0);
        check("rst_id", id_out, 45'd0);
        reset = 1'b0;

        // restart pulse length, then ARM
        rcnt = 0;
        k = 0;
        while (state != 2'd1 && k < 20) begin
            step();
            k++;
            if (dec_restart) rcnt++;
        end
        check("restart_len", 45'(rcnt), 45'd4);
        check("arm_state", 45'(state), 45'd1);
        check("arm_restart", 45'(dec_restart), 45'd0);

        // ARM timeout after 100 cycles, restart repeats
        k = 0;
        seen = 1'b0;
        while (!timeout && k < 300) begin
            step();
            k++;
            if (id_valid) seen = 1'b1;
        end
        check("tmo_delay", 45'(k), 45'd100);
        check("tmo_state", 45'(state), 45'd0);
        check("tmo_restart", 45'(dec_restart), 45'd1);
        step();
        check("tmo_pulse1", 45'(timeout), 45'd0);
        check("tmo_idv", 45'(seen), 45'd0);
        wait_state("rearm", 2'd1);

        // three good A frames, 20 cycles apart
        send(A);
        check("a1_state", 45'(state), 45'd2);
        idle(19);
        send(A);
        check("a2_state", 45'(state), 45'd2);
        check("a2_new", 45'(id_new), 45'd0);
        idle(19);
        send(A);
        check("a3_state", 45'(state), 45'd3);
        check("a3_id", id_out, A);
        check("a3_idv", 45'(id_valid), 45'd1);
        check("a3_new", 45'(id_new), 45'd1);
        step();
        check("a3_new_end", 45'(id_new), 45'd0);

        // refresh every 150 cycles keeps the ID
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (i % 150 == 0) send(A);
            else step();
            if (!id_valid || id_new) seen = 1'b1;
        end
        check("refresh_hold", 45'(seen), 45'd0);
        send(A);
        k = 0;
        while (id_valid && k < 400) begin
            step();
            k++;
        end
        check("hold_delay", 45'(k), 45'd200);
        check("hold_state", 45'(state), 45'd0);
        wait_state("rearm2", 2'd1);

        // A,B,B,B commits B on the fourth frame
        send(A);
        check("ab_s1", 45'(state), 45'd2);
        idle(5);
        send(B);
        check("ab_s2", 45'(state), 45'd2);
        idle(5);
        send(B);
        check("ab_s3", 45'(state), 45'd2);
        check("ab_new3", 45'(id_new), 45'd0);
        idle(5);
        send(B);
        check("ab_s4", 45'(state), 45'd3);
        check("ab_id", id_out, B);
        check("ab_new4", 45'(id_new), 45'd1);

        // reset while LOCKED
        idle(3);
        do_reset();
        check("lrst_state", 45'(state), 45'd0);
        check("lrst_idv", 45'(id_valid), 45'd0);
        check("lrst_id", id_out, 45'd0);
        check("lrst_restart", 45'(dec_restart), 45'd0);
        wait_state("rearm3", 2'd1);

        // A, bad header, A, A: no commit until a third A
        send(A);
        idle(3);
        send(BAD);
        check("bad_err", 45'(err_cnt), 45'd1);
        check("bad_state", 45'(state), 45'd1);
        idle(3);
        send(A);
        idle(3);
        send(A);
        check("bad_s", 45'(state), 45'd2);
        check("bad_idv", 45'(id_valid), 45'd0);
        idle(3);
        send(A);
        check("bad_commit", 45'(state), 45'd3);
        check("bad_new", 45'(id_new), 45'd1);

        // good frame on terminal timeout cycle wins
        do_reset();
        wait_state("rearm4", 2'd1);
        idle(99);
        send(A);
        check("term_tmo", 45'(timeout), 45'd0);
        check("term_state", 45'(state), 45'd2);

        // CONFIRM timeout drops back to IDLE
        k = 0;
        while (!timeout && k < 300) begin
            step();
            k++;
        end
        check("cf_tmo", 45'(k), 45'd100);
        check("cf_state", 45'(state), 45'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
